// File: rtl/mult_property_checker.sv
// mult_property_checker: two shift-add multiplier lanes (a*b and b*a) run in
// lockstep on one operand pair. Each result is checked for commutativity,
// for timing symmetry between the lanes, and for latency leakage across ops
// that share the same public operand.
module mult_property_checker #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned EARLY_EXIT = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         ready,
   input  logic [WIDTH-1:0]             op_a,
   input  logic [WIDTH-1:0]             op_b,
   output logic                         done,
   output logic [2*WIDTH-1:0]           product,
   output logic [$clog2(WIDTH+1)-1:0]   lat_a,
   output logic [$clog2(WIDTH+1)-1:0]   lat_b,
   output logic                         comm_ok,
   output logic                         timing_leak,
   output logic                         xop_leak,
   output logic                         comm_fail_sticky,
   output logic                         leak_sticky,
   output logic [CNT_W-1:0]             op_count
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned LAT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] mreg_a_q, mreg_a_d, mreg_b_q, mreg_b_d;
   logic [PW-1:0]    dreg_a_q, dreg_a_d, dreg_b_q, dreg_b_d;
   logic [PW-1:0]    acc_a_q, acc_a_d, acc_b_q, acc_b_d;
   logic [LAT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [WIDTH-1:0] cur_b_q, cur_b_d, prev_b_q, prev_b_d;
   logic [LAT_W-1:0] prev_lat_q, prev_lat_d;
   logic             prev_valid_q, prev_valid_d;

   logic             ready_q, ready_d, done_q, done_d;
   logic [PW-1:0]    product_q, product_d;
   logic [LAT_W-1:0] lat_a_q, lat_a_d, lat_b_q, lat_b_d;
   logic             comm_ok_q, comm_ok_d, timing_leak_q, timing_leak_d;
   logic             xop_leak_q, xop_leak_d;
   logic             comm_fail_q, comm_fail_d, leak_sticky_q, leak_sticky_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             fin_a_c, fin_b_c;
   logic             comm_now_c, tleak_now_c, xleak_now_c;

   // A lane is finished at WIDTH iterations, or early once its multiplier is exhausted
   assign fin_a_c = (cnt_a_q == LAT_W'(WIDTH)) || ((EARLY_EXIT != 0) && (mreg_a_q == '0));
   assign fin_b_c = (cnt_b_q == LAT_W'(WIDTH)) || ((EARLY_EXIT != 0) && (mreg_b_q == '0));

   assign comm_now_c  = (acc_a_q == acc_b_q);
   assign tleak_now_c = (cnt_a_q != cnt_b_q);
   assign xleak_now_c = prev_valid_q && (cur_b_q == prev_b_q) && (cnt_a_q != prev_lat_q);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (fin_a_c && fin_b_c) state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lane datapath and result/flag next values
   always_comb begin
      mreg_a_d      = mreg_a_q;
      mreg_b_d      = mreg_b_q;
      dreg_a_d      = dreg_a_q;
      dreg_b_d      = dreg_b_q;
      acc_a_d       = acc_a_q;
      acc_b_d       = acc_b_q;
      cnt_a_d       = cnt_a_q;
      cnt_b_d       = cnt_b_q;
      cur_b_d       = cur_b_q;
      prev_b_d      = prev_b_q;
      prev_lat_d    = prev_lat_q;
      prev_valid_d  = prev_valid_q;
      product_d     = product_q;
      lat_a_d       = lat_a_q;
      lat_b_d       = lat_b_q;
      comm_ok_d     = comm_ok_q;
      timing_leak_d = timing_leak_q;
      xop_leak_d    = xop_leak_q;
      comm_fail_d   = comm_fail_q;
      leak_sticky_d = leak_sticky_q;
      op_count_d    = op_count_q;
      done_d        = 1'b0;
      ready_d       = (state_d == IDLE);
      case (state_q)
         IDLE: begin
            if (start) begin
               mreg_a_d = op_a;
               dreg_a_d = PW'(op_b);
               mreg_b_d = op_b;
               dreg_b_d = PW'(op_a);
               acc_a_d  = '0;
               acc_b_d  = '0;
               cnt_a_d  = '0;
               cnt_b_d  = '0;
               cur_b_d  = op_b;
            end
         end
         RUN: begin
            if (!fin_a_c) begin
               if (mreg_a_q[0]) acc_a_d = acc_a_q + dreg_a_q;
               mreg_a_d = mreg_a_q >> 1;
               dreg_a_d = dreg_a_q << 1;
               cnt_a_d  = cnt_a_q + LAT_W'(1);
            end
            if (!fin_b_c) begin
               if (mreg_b_q[0]) acc_b_d = acc_b_q + dreg_b_q;
               mreg_b_d = mreg_b_q >> 1;
               dreg_b_d = dreg_b_q << 1;
               cnt_b_d  = cnt_b_q + LAT_W'(1);
            end
         end
         CHECK: begin
            product_d     = acc_a_q;
            lat_a_d       = cnt_a_q;
            lat_b_d       = cnt_b_q;
            comm_ok_d     = comm_now_c;
            timing_leak_d = tleak_now_c;
            xop_leak_d    = xleak_now_c;
            prev_b_d      = cur_b_q;
            prev_lat_d    = cnt_a_q;
            prev_valid_d  = 1'b1;
            comm_fail_d   = comm_fail_q | ~comm_now_c;
            leak_sticky_d = leak_sticky_q | tleak_now_c | xleak_now_c;
            if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + CNT_W'(1);
            done_d        = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and output registers; ready comes out of reset already high
   always_ff @(posedge clk) begin
      if (rst) begin
         mreg_a_q      <= '0;
         mreg_b_q      <= '0;
         dreg_a_q      <= '0;
         dreg_b_q      <= '0;
         acc_a_q       <= '0;
         acc_b_q       <= '0;
         cnt_a_q       <= '0;
         cnt_b_q       <= '0;
         cur_b_q       <= '0;
         prev_b_q      <= '0;
         prev_lat_q    <= '0;
         prev_valid_q  <= 1'b0;
         ready_q       <= 1'b1;
         done_q        <= 1'b0;
         product_q     <= '0;
         lat_a_q       <= '0;
         lat_b_q       <= '0;
         comm_ok_q     <= 1'b0;
         timing_leak_q <= 1'b0;
         xop_leak_q    <= 1'b0;
         comm_fail_q   <= 1'b0;
         leak_sticky_q <= 1'b0;
         op_count_q    <= '0;
      end else begin
         mreg_a_q      <= mreg_a_d;
         mreg_b_q      <= mreg_b_d;
         dreg_a_q      <= dreg_a_d;
         dreg_b_q      <= dreg_b_d;
         acc_a_q       <= acc_a_d;
         acc_b_q       <= acc_b_d;
         cnt_a_q       <= cnt_a_d;
         cnt_b_q       <= cnt_b_d;
         cur_b_q       <= cur_b_d;
         prev_b_q      <= prev_b_d;
         prev_lat_q    <= prev_lat_d;
         prev_valid_q  <= prev_valid_d;
         ready_q       <= ready_d;
         done_q        <= done_d;
         product_q     <= product_d;
         lat_a_q       <= lat_a_d;
         lat_b_q       <= lat_b_d;
         comm_ok_q     <= comm_ok_d;
         timing_leak_q <= timing_leak_d;
         xop_leak_q    <= xop_leak_d;
         comm_fail_q   <= comm_fail_d;
         leak_sticky_q <= leak_sticky_d;
         op_count_q    <= op_count_d;
      end
   end

   assign ready            = ready_q;
   assign done             = done_q;
   assign product          = product_q;
   assign lat_a            = lat_a_q;
   assign lat_b            = lat_b_q;
   assign comm_ok          = comm_ok_q;
   assign timing_leak      = timing_leak_q;
   assign xop_leak         = xop_leak_q;
   assign comm_fail_sticky = comm_fail_q;
   assign leak_sticky      = leak_sticky_q;
   assign op_count         = op_count_q;

endmodule
